rom_sequencer: RTL and testbench
================================

// Module: rom_sequencer
// PURPOSE
//  Frame-synchronous controller for the 16x8 test-pattern command ROM. On each frame tick it
//  walks the ROM from START_ADDR, decodes each byte into a header or opcode, and issues draw
//  commands over a valid/ready handshake to the VGA pattern renderer.
//  It sits between the sync generator (frame tick) and the renderer. It owns the ROM address bus.
// PARAMETERS
//  ADDR_W      4     ROM address width; depth = 2**ADDR_W
//  DATA_W      8     ROM word width; high nibble = opcode, low nibble = operand
//  START_ADDR  0     first address fetched on each frame
// PORTS
//  clk          in   1       system clock
//  reset        in   1       asynchronous reset, active-high
//  frame_start  in   1       single-cycle pulse at start of vertical blanking
//  rom_dir      out  ADDR_W  ROM address (ROM is combinational; data valid same cycle)
//  rom_data     in   DATA_W  ROM word at rom_dir
//  cmd_valid    out  1       draw command available
//  cmd_ready    in   1       renderer accepts command when cmd_valid && cmd_ready
//  cmd_x        out  8       origin X (header byte 0)
//  cmd_y        out  8       origin Y (header byte 1)
//  cmd_seg      out  4       segment index to draw
//  cmd_color    out  4       current colour
//  cmd_scale    out  4       current scale
//  busy         out  1       high from accepted frame_start until the cycle done pulses
//  done         out  1       one-cycle pulse when the program ends
//  overrun      out  1       sticky; frame_start arrived while busy; cleared by reset only
// BEHAVIOUR
//  Reset: state IDLE, rom_dir=START_ADDR, cmd_valid=0, cmd_x=cmd_y=0, cmd_seg=0, cmd_color=0,
//   cmd_scale=1, busy=0, done=0, overrun=0.
//  FSM states: IDLE -> HDR_X -> HDR_Y -> EXEC <-> DRAW -> DONE -> IDLE.
//   IDLE: on frame_start go to HDR_X, set busy=1 and rom_dir=START_ADDR, and reset colour to 0
//    and scale to 1.
//   HDR_X: cmd_x<=rom_data; addr+1. HDR_Y: cmd_y<=rom_data; addr+1. Each takes 1 cycle.
//   EXEC: each cycle decodes rom_data[7:4]:
//    0x0 with operand 0 = END -> DONE. 0x0 with operand !=0 = NOP.
//    0x1 = SET_COLOR (operand). 0xF = SET_SCALE (operand; 0 is coerced to 1).
//    0x2 = DRAW: load cmd_seg and go to DRAW.
//    Any other opcode is a NOP.
//    Each non-DRAW opcode takes 1 cycle and advances addr.
//   DRAW: cmd_valid=1 with all cmd_* held stable. On cmd_valid&&cmd_ready: cmd_valid<=0,
//    advance addr, return to EXEC. No bound on stall length.
//   DONE: done=1 and busy=0 for one cycle, then IDLE.
//  Wrap-around: the address never wraps. After the entry at the last address (2**ADDR_W-1)
//   completes, an implicit END occurs; a DRAW there first completes its handshake.
//  Header at end of ROM: if START_ADDR is the last address, HDR_Y reads the same word and END
//   follows.
//  frame_start while busy (including in the DONE cycle): ignored; overrun<=1. Not queued.
//  frame_start in the same cycle busy returns to IDLE is ignored.
//  Latency: frame_start to first cmd_valid = 3 + (number of non-DRAW opcodes before it) cycles.
//  Reset asserted mid-frame: immediate return to reset values; no done pulse; no partial command
//   held.
// STRUCTURE
//  Shared package (vga_pkg): opcode localparams (OP_CTRL=4'h0, OP_COLOR=4'h1, OP_DRAW=4'h2,
//   OP_SCALE=4'hF) and the FSM state encoding. The ROM and any future pattern ROMs use the
//   same opcode set.
//  No sub-module: the FSM, address counter and command registers live in one always block
//   plus output logic. ROM is instantiated by the parent, not inside this block.
// TESTING
//  Bench uses the stock ROM (02,02,10,F1,21..26,00...).
//  1. Reset, pulse frame_start, hold cmd_ready=1
//     -> six commands, x=2, y=2, color=0, scale=1, seg=1..6 in order; done pulses once;
//        rom_dir stops at 0xA.
//  2. Same, with cmd_ready low for 5 cycles on seg=3
//     -> cmd_valid stays high and cmd_* stay stable; seg=3 is delivered exactly once;
//        no address advance while stalled.
//  3. Second frame_start while busy -> overrun=1; command stream unchanged; no restart.
//  4. Assert reset during DRAW of seg=4 -> next cycle all outputs at reset values;
//     a later frame_start replays from seg=1.
//  5. Alternate ROM with no 0x00 and 0x23 at 0xF
//     -> the final DRAW seg=3 completes, then done; rom_dir never returns to 0.
//  6. Alternate ROM with 0xF0 and 0x35 -> cmd_scale=1 and 0x35 is a NOP;
//     cycle count matches the latency rule.

Source files
------------

// File: rtl/vga_pkg.sv
// Opcode set and sequencer state encoding shared by the
// pattern ROM sequencer and any future pattern ROMs.
package vga_pkg;

  localparam logic [3:0] OP_CTRL  = 4'h0;
  localparam logic [3:0] OP_COLOR = 4'h1;
  localparam logic [3:0] OP_DRAW  = 4'h2;
  localparam logic [3:0] OP_SCALE = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_X,
    ST_HDR_Y,
    ST_EXEC,
    ST_DRAW,
    ST_DONE
  } state_t;

  // A zero scale would render nothing; treat it as unity.
  function automatic logic [3:0] scale_of(
    input logic [3:0] opr
  );
    return (opr == 4'h0) ? 4'h1 : opr;
  endfunction

endpackage

// File: rtl/rom_sequencer_if.sv
// ROM address/data bus plus the draw-command
// valid/ready channel towards the renderer.
interface rom_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);

  logic [ADDR_W-1:0] rom_dir;
  logic [DATA_W-1:0] rom_data;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_x;
  logic [7:0]        cmd_y;
  logic [3:0]        cmd_seg;
  logic [3:0]        cmd_color;
  logic [3:0]        cmd_scale;

  modport master (
    output rom_dir,
    input  rom_data,
    output cmd_valid,
    input  cmd_ready,
    output cmd_x,
    output cmd_y,
    output cmd_seg,
    output cmd_color,
    output cmd_scale
  );

  modport slave (
    input  rom_dir,
    output rom_data,
    input  cmd_valid,
    output cmd_ready,
    input  cmd_x,
    input  cmd_y,
    input  cmd_seg,
    input  cmd_color,
    input  cmd_scale
  );

endinterface

// File: rtl/rom_sequencer.sv
// Frame-synchronous walker of the test-pattern ROM:
// header (x, y) then opcodes, issuing draw commands.
module rom_sequencer
  import vga_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int START_ADDR = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            frame_start,
  rom_sequencer_if.master bus,
  output logic            busy,
  output logic            done,
  output logic            overrun
);

  localparam logic [ADDR_W-1:0] START =
    ADDR_W'(START_ADDR);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        x_q, x_d;
  logic [7:0]        y_q, y_d;
  logic [3:0]        seg_q, seg_d;
  logic [3:0]        color_q, color_d;
  logic [3:0]        scale_q, scale_d;
  logic              ovr_q, ovr_d;

  logic [3:0]        opc;
  logic [3:0]        opr;
  logic              at_last;
  logic              is_end;
  logic              is_draw;
  logic              is_color;
  logic              is_scale;
  logic              step;
  logic              accept;
  logic [ADDR_W-1:0] addr_inc;

  assign opc      = bus.rom_data[DATA_W-1 -: 4];
  assign opr      = bus.rom_data[3:0];
  assign at_last  = &addr_q;
  assign addr_inc = addr_q + ADDR_W'(1);
  assign is_end   = (opc == OP_CTRL) &&
                    (opr == 4'h0);
  assign is_draw  = (opc == OP_DRAW);
  assign is_color = (opc == OP_COLOR);
  assign is_scale = (opc == OP_SCALE);
  assign accept   = bus.cmd_valid &&
                    bus.cmd_ready;
  // The address saturates at the top: no wrap.
  assign step     = !is_draw && !is_end &&
                    !at_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= START;
      x_q     <= '0;
      y_q     <= '0;
      seg_q   <= '0;
      color_q <= '0;
      scale_q <= 4'h1;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      seg_q   <= seg_d;
      color_q <= color_d;
      scale_q <= scale_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) state_d = ST_HDR_X;
      end
      ST_HDR_X: state_d = ST_HDR_Y;
      ST_HDR_Y: begin
        state_d = at_last ? ST_DONE : ST_EXEC;
      end
      ST_EXEC: begin
        if (is_end)       state_d = ST_DONE;
        else if (is_draw) state_d = ST_DRAW;
        else if (at_last) state_d = ST_DONE;
        else              state_d = ST_EXEC;
      end
      ST_DRAW: begin
        if (accept) begin
          state_d = at_last ? ST_DONE : ST_EXEC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    seg_d   = seg_q;
    color_d = color_q;
    scale_d = scale_q;
    ovr_d   = ovr_q ||
              (frame_start && state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          addr_d  = START;
          color_d = '0;
          scale_d = 4'h1;
        end
      end
      ST_HDR_X: begin
        x_d = bus.rom_data[7:0];
        if (!at_last) addr_d = addr_inc;
      end
      ST_HDR_Y: begin
        y_d = bus.rom_data[7:0];
        if (!at_last) addr_d = addr_inc;
      end
      ST_EXEC: begin
        unique case (1'b1)
          is_color: color_d = opr;
          is_scale: scale_d = scale_of(opr);
          is_draw:  seg_d   = opr;
          default:  ;
        endcase
        if (step) addr_d = addr_inc;
      end
      ST_DRAW: begin
        if (accept && !at_last) addr_d = addr_inc;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    bus.cmd_valid = 1'b0;
    unique case (state_q)
      ST_HDR_X, ST_HDR_Y, ST_EXEC: busy = 1'b1;
      ST_DRAW: begin
        busy          = 1'b1;
        bus.cmd_valid = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign bus.rom_dir   = addr_q;
  assign bus.cmd_x     = x_q;
  assign bus.cmd_y     = y_q;
  assign bus.cmd_seg   = seg_q;
  assign bus.cmd_color = color_q;
  assign bus.cmd_scale = scale_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_rom_sequencer.sv
// Directed and randomized checks of rom_sequencer
// against a program-level walk of the ROM contents.
module tb_rom_sequencer;

  localparam int MAXC = 400;

  logic clk = 1'b0;
  logic reset;
  logic frame_start;
  logic busy;
  logic done;
  logic overrun;

  logic [7:0] rom [16];

  int compared   = 0;
  int mismatched = 0;

  logic [23:0] exp_q[$];
  int          exp_lat;
  int          exp_addr;
  logic        exp_ovr = 1'b0;

  rom_sequencer_if bus ();

  rom_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  assign bus.rom_data = rom[bus.rom_dir];

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] cmd_now();
    return {bus.cmd_x, bus.cmd_y, bus.cmd_seg,
            bus.cmd_color, bus.cmd_scale};
  endfunction

  function automatic logic [35:0] rst_view();
    return {bus.rom_dir, bus.cmd_valid,
            bus.cmd_x, bus.cmd_y, bus.cmd_seg,
            bus.cmd_color, bus.cmd_scale,
            busy, done, overrun};
  endfunction

  localparam logic [35:0] RST_VAL =
    {4'h0, 1'b0, 8'h0, 8'h0, 4'h0,
     4'h0, 4'h1, 3'b000};

  // Program-level walk: header, then opcodes until END
  // or the last address; latency counts 1 cycle per op.
  task automatic model_frame();
    int a;
    int t;
    logic [7:0] x, y, b;
    logic [3:0] col, scl;
    bit stop;
    exp_q.delete();
    exp_lat = -1;
    a = 0;
    x = rom[a];
    if (a < 15) a++;
    y = rom[a];
    col = 4'h0;
    scl = 4'h1;
    t = 3;
    stop = (a == 15);
    if (!stop) a++;
    while (!stop) begin
      b = rom[a];
      if (b == 8'h00) begin
        stop = 1;
      end else begin
        if (b[7:4] == 4'h2) begin
          exp_q.push_back({x, y, b[3:0], col, scl});
          if (exp_lat < 0) exp_lat = t;
        end else begin
          if (b[7:4] == 4'h1) col = b[3:0];
          if (b[7:4] == 4'hF)
            scl = (b[3:0] == 0) ? 4'h1 : b[3:0];
          t++;
        end
        if (a == 15) stop = 1;
        else a++;
      end
    end
    exp_addr = a;
  endtask

  task automatic run_frame(input int stall_seg,
                           input int inject_at,
                           input int abort_seg,
                           input bit rand_rdy);
    logic [23:0] got_q[$];
    logic [23:0] snap;
    logic [3:0]  snap_a;
    logic [3:0]  prev_a;
    int n = 0;
    int lat = -1;
    int dones = 0;
    int stalls = 0;
    bit stalled = 0;
    bit wrapped = 0;
    bit fin = 0;
    model_frame();
    frame_start = 1'b1;
    prev_a = 4'h0;
    while (!fin) begin
      @(negedge clk);
      n++;
      frame_start = (n == inject_at);
      if (stalled) begin
        chk("stall_valid", 64'(bus.cmd_valid), 64'd1);
        chk("stall_cmd", 64'(cmd_now()), 64'(snap));
        chk("stall_addr", 64'(bus.rom_dir),
            64'(snap_a));
      end
      if (bus.cmd_valid && lat < 0) lat = n - 1;
      if (bus.cmd_valid && stalls < 5 &&
          int'(bus.cmd_seg) == stall_seg) begin
        bus.cmd_ready = 1'b0;
        stalls++;
      end else if (rand_rdy) begin
        bus.cmd_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.cmd_ready = 1'b1;
      end
      if (abort_seg >= 0 && bus.cmd_valid &&
          int'(bus.cmd_seg) == abort_seg) begin
        reset = 1'b1;
        #1;
        chk("abort_rst", 64'(rst_view()),
            64'(RST_VAL));
        @(negedge clk);
        chk("abort_hold", 64'(rst_view()),
            64'(RST_VAL));
        reset = 1'b0;
        frame_start = 1'b0;
        bus.cmd_ready = 1'b1;
        return;
      end
      stalled = bus.cmd_valid && !bus.cmd_ready;
      snap    = cmd_now();
      snap_a  = bus.rom_dir;
      if (bus.cmd_valid && bus.cmd_ready)
        got_q.push_back(cmd_now());
      if (n >= 2 && bus.rom_dir < prev_a)
        wrapped = 1;
      prev_a = bus.rom_dir;
      if (done) begin
        dones++;
        chk("busy_at_done", 64'(busy), 64'd0);
        fin = 1;
      end
      if (n > MAXC) begin
        chk("timeout", 64'd0, 64'd1);
        fin = 1;
      end
    end
    frame_start = 1'b0;
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("done_cnt", 64'(dones), 64'd1);
    chk("ncmd", 64'(got_q.size()),
        64'(exp_q.size()));
    for (int i = 0; i < got_q.size() &&
         i < exp_q.size(); i++)
      chk($sformatf("cmd%0d", i), 64'(got_q[i]),
          64'(exp_q[i]));
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("end_addr", 64'(bus.rom_dir),
        64'(exp_addr));
    chk("overrun", 64'(overrun), 64'(exp_ovr));
    chk("no_wrap", 64'(wrapped), 64'd0);
  endtask

  task automatic load_stock();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'h02;
    rom[1] = 8'h02;
    rom[2] = 8'h10;
    rom[3] = 8'hF1;
    for (int i = 0; i < 6; i++)
      rom[4+i] = 8'h21 + 8'(i);
  endtask

  task automatic load_random();
    int r;
    rom[0] = 8'($urandom);
    rom[1] = 8'($urandom);
    for (int i = 2; i < 16; i++) begin
      r = $urandom_range(0, 11);
      case (r)
        0:       rom[i] = 8'h00;
        1:       rom[i] = {4'h0,
                   4'($urandom_range(1, 15))};
        2:       rom[i] = {4'h1, 4'($urandom)};
        3, 4:    rom[i] = {4'hF, 4'($urandom)};
        5, 6, 7,
        8:       rom[i] = {4'h2, 4'($urandom)};
        default: rom[i] = {
                   4'($urandom_range(3, 14)),
                   4'($urandom)};
      endcase
    end
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    bus.cmd_ready = 1'b1;
    load_stock();
    repeat (3) @(negedge clk);
    chk("reset_state", 64'(rst_view()),
        64'(RST_VAL));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_state", 64'(rst_view()),
        64'(RST_VAL));

    run_frame(-1, -1, -1, 1'b0);
    run_frame(3, -1, -1, 1'b0);

    exp_ovr = 1'b1;
    run_frame(-1, 8, -1, 1'b0);

    run_frame(-1, -1, 4, 1'b0);
    exp_ovr = 1'b0;
    run_frame(-1, -1, -1, 1'b0);

    for (int i = 0; i < 16; i++) rom[i] = 8'h01;
    rom[0] = 8'h05;
    rom[1] = 8'h07;
    rom[2] = 8'h11;
    rom[3] = 8'h21;
    rom[4] = 8'hF2;
    rom[5] = 8'h22;
    rom[6] = 8'h34;
    rom[15] = 8'h23;
    run_frame(-1, -1, -1, 1'b0);
    run_frame(15, -1, -1, 1'b1);

    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'h01;
    rom[1] = 8'h02;
    rom[2] = 8'hF3;
    rom[3] = 8'hF0;
    rom[4] = 8'h35;
    rom[5] = 8'h22;
    run_frame(-1, -1, -1, 1'b0);

    for (int k = 0; k < 8; k++) begin
      load_random();
      run_frame(-1, -1, -1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
